// File: rtl/dm_pkg.sv
// Shared definitions for the handshaked data memory: DmCtrl encodings, FSM states
// and access-legality helpers.
package dm_pkg;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dm_state_t;

  function automatic logic is_legal(input logic [2:0] ctrl);
    return (ctrl == DM_B) || (ctrl == DM_H) || (ctrl == DM_W) ||
           (ctrl == DM_BU) || (ctrl == DM_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] addr);
    return ((ctrl[1:0] == 2'b01) && addr[0]) ||
           ((ctrl[1:0] == 2'b10) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load path: picks the byte/half/word lane out of a memory word and sign- or
// zero-extends it. Halves use offset[1] only, so odd half addresses fold down.
module dm_lane_ext (
  input  logic [31:0] word,
  input  logic [2:0]  ctrl,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    data   = '0;
    case (ctrl[1:0])
      2'b00:   data = ctrl[2] ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   data = ctrl[2] ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
      2'b10:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// Byte-addressed data memory with valid/ready request, WAIT_CYCLES wait states and a
// one-cycle response. Optional macro DM_ERR_EN adds the err port and rejects misaligned accesses.
//
//  state | meaning
//  IDLE  | req_ready high, waiting for a request
//  BUSY  | request latched, cnt counts wait states down to zero, access on terminal count
//  RESP  | rsp_valid high with DataRd (and err) for one cycle
module data_mem_hs
  import dm_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0,
  parameter int DW          = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] address,
  input  logic [31:0] DataWr,
  input  logic        DmWr,
  input  logic [2:0]  DmCtrl,
  output logic        rsp_valid,
  output logic [31:0] DataRd
`ifdef DM_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int AW = $clog2(DEPTH);

  if (DW != 32) begin : g_dw_chk
    $error("data_mem_hs: DW must be 32");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("data_mem_hs: DEPTH must be a power of two >= 4");
  end
  if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_wait_chk
    $error("data_mem_hs: WAIT_CYCLES must be 0..15");
  end

  dm_state_t     state;
  logic [3:0]    cnt;
  logic [AW+1:0] a_addr;
  logic [31:0]   a_data;
  logic          a_wr;
  logic [2:0]    a_ctrl;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          reject;
  logic          do_access;
  logic          do_write;
  logic          unused_addr;

  // Upper address bits only alias the array.
  assign unused_addr = ^address[31:AW+2];

  assign req_ready = (state == IDLE) && !rst;
  assign idx       = a_addr[AW+1:2];
  assign rd_word   = mem[idx];
  assign do_access = (state == BUSY) && (cnt == 4'd0) && !rst;
`ifdef DM_ERR_EN
  assign reject    = !is_legal(a_ctrl) || is_misaligned(a_ctrl, a_addr[1:0]);
`else
  assign reject    = !is_legal(a_ctrl);
`endif
  assign do_write  = do_access && a_wr && !reject;

  always_comb begin
    be    = '0;
    wdata = '0;
    case (a_ctrl[1:0])
      2'b00: begin
        be    = 4'b0001 << a_addr[1:0];
        wdata = {4{a_data[7:0]}};
      end
      2'b01: begin
        be    = a_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{a_data[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wdata = a_data;
      end
      default: ;
    endcase
  end

  dm_lane_ext u_lane_ext (
    .word   (rd_word),
    .ctrl   (a_ctrl),
    .offset (a_addr[1:0]),
    .data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      DataRd    <= '0;
`ifdef DM_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      DataRd    <= '0;
`ifdef DM_ERR_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_addr <= address[AW+1:0];
            a_data <= DataWr;
            a_wr   <= DmWr;
            a_ctrl <= DmCtrl;
            cnt    <= 4'(WAIT_CYCLES);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            DataRd    <= (a_wr || reject) ? 32'h0 : ld_data;
`ifdef DM_ERR_EN
            err       <= reject;
`endif
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Self-checking bench for data_mem_hs: two instances (WAIT_CYCLES 0 and 3) checked against
// a byte-array reference model. Honours DM_ERR_EN the same way as the design.
module tb_data_mem_hs;

  logic        clk = 1'b0;
  logic        rst0, rst3;
  logic        rv0, rv3;
  logic [31:0] address;
  logic [31:0] DataWr;
  logic        DmWr;
  logic [2:0]  DmCtrl;
  logic        rdy0, rdy3, rsp0, rsp3;
  logic [31:0] rd0, rd3;
  logic        err0, err3;

  int tests = 0;
  int fails = 0;

  logic [7:0] mb [2][256];

  always #5 clk = ~clk;

  data_mem_hs #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(rv0), .req_ready(rdy0),
    .address(address), .DataWr(DataWr), .DmWr(DmWr), .DmCtrl(DmCtrl),
    .rsp_valid(rsp0), .DataRd(rd0)
`ifdef DM_ERR_EN
    , .err(err0)
`endif
  );

  data_mem_hs #(.DEPTH(64), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(rv3), .req_ready(rdy3),
    .address(address), .DataWr(DataWr), .DmWr(DmWr), .DmCtrl(DmCtrl),
    .rsp_valid(rsp3), .DataRd(rd3)
`ifdef DM_ERR_EN
    , .err(err3)
`endif
  );

`ifndef DM_ERR_EN
  assign err0 = 1'b0;
  assign err3 = 1'b0;
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic g_rdy(input int w);
    return (w == 0) ? rdy0 : rdy3;
  endfunction
  function automatic logic g_rsp(input int w);
    return (w == 0) ? rsp0 : rsp3;
  endfunction
  function automatic logic [31:0] g_rd(input int w);
    return (w == 0) ? rd0 : rd3;
  endfunction
  function automatic logic g_err(input int w);
    return (w == 0) ? err0 : err3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as 256 bytes, access width n bytes, base address rounded down to n.
  function automatic void model(input int w, input logic wr, input logic [2:0] ctrl,
                                input logic [31:0] addr, input logic [31:0] data,
                                output logic [31:0] erd, output logic eerr);
    int n, base;
    logic legal;
    logic [31:0] v, d;
    erd  = 32'h0;
    eerr = 1'b0;
    legal = (ctrl == 3'b000) || (ctrl == 3'b001) || (ctrl == 3'b010) ||
            (ctrl == 3'b100) || (ctrl == 3'b101);
    n = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
`ifdef DM_ERR_EN
    if (!legal || ((int'(addr[1:0]) % n) != 0)) begin
      eerr = 1'b1;
      return;
    end
`else
    if (!legal) return;
`endif
    base = (int'(addr[7:0]) / n) * n;
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        d = data >> (8 * i);
        mb[w][base + i] = d[7:0];
      end
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[w][base + i]) << (8 * i));
      if (!ctrl[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      erd = v;
    end
  endfunction

  task automatic drive(input int w, input logic wr, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] data);
    address = addr;
    DataWr  = data;
    DmWr    = wr;
    DmCtrl  = ctrl;
    if (w == 0) rv0 = 1'b1; else rv3 = 1'b1;
  endtask

  task automatic txn(input int w, input logic wr, input logic [2:0] ctrl,
                     input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] erd;
    logic eerr;
    int got, lat;
    lat = (w == 0) ? 2 : 5;
    @(negedge clk);
    drive(w, wr, ctrl, addr, data);
    chk("ready_idle", 32'(g_rdy(w)), 32'd1);
    @(posedge clk);
    model(w, wr, ctrl, addr, data, erd, eerr);
    got = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rv0 = 1'b0;
        rv3 = 1'b0;
      end
      if (g_rsp(w)) begin
        got = k;
        break;
      end
      chk("ready_busy", 32'(g_rdy(w)), 32'd0);
    end
    chk("latency", got, lat);
    chk("datard", g_rd(w), erd);
`ifdef DM_ERR_EN
    chk("err", 32'(g_err(w)), 32'(eerr));
`endif
    @(negedge clk);
    chk("rsp_one_cycle", 32'(g_rsp(w)), 32'd0);
    chk("ready_back", 32'(g_rdy(w)), 32'd1);
  endtask

  initial begin
    logic [31:0] erd;
    logic eerr;
    int low, nrsp, rcyc, got;

    rst0 = 1'b1; rst3 = 1'b1; rv0 = 1'b0; rv3 = 1'b0;
    address = '0; DataWr = '0; DmWr = 1'b0; DmCtrl = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 32'(rdy0), 32'd0);
    chk("rst_ready3", 32'(rdy3), 32'd0);
    chk("rst_rsp0", 32'(rsp0), 32'd0);
    chk("rst_rsp3", 32'(rsp3), 32'd0);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_err0", 32'(err0), 32'd0);
    rst0 = 1'b0; rst3 = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(rdy0), 32'd1);

    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 64; i++) txn(w, 1'b1, 3'b010, 32'(i * 4), $urandom);

    // Basic word, byte and half accesses with WAIT_CYCLES=0
    txn(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0);
    txn(0, 1'b1, 3'b010, 32'h10, 32'h0);
    txn(0, 1'b1, 3'b000, 32'h13, 32'h80);
    txn(0, 1'b0, 3'b000, 32'h13, 32'h0);
    txn(0, 1'b0, 3'b100, 32'h13, 32'h0);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0);
    txn(0, 1'b1, 3'b010, 32'h20, 32'h1111_2222);
    txn(0, 1'b1, 3'b001, 32'h22, 32'h8001);
    txn(0, 1'b0, 3'b001, 32'h22, 32'h0);
    txn(0, 1'b0, 3'b101, 32'h22, 32'h0);
    txn(0, 1'b0, 3'b010, 32'h20, 32'h0);
    // Misaligned, illegal and aliasing
    txn(0, 1'b0, 3'b010, 32'h11, 32'h0);
    txn(0, 1'b1, 3'b010, 32'h12, 32'hCAFE_F00D);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0);
    txn(0, 1'b1, 3'b011, 32'h30, 32'h5555_5555);
    txn(0, 1'b0, 3'b010, 32'h30, 32'h0);
    txn(0, 1'b0, 3'b111, 32'h30, 32'h0);
    txn(0, 1'b1, 3'b010, 32'h100, 32'hA5A5_0F0F);
    txn(0, 1'b0, 3'b010, 32'h000, 32'h0);

    // WAIT_CYCLES=3 with req_valid held high across two back-to-back requests
    @(negedge clk);
    drive(1, 1'b0, 3'b010, 32'h10, 32'h0);
    @(posedge clk);
    model(1, 1'b0, 3'b010, 32'h10, 32'h0, erd, eerr);
    low = 0; nrsp = 0; rcyc = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (!rdy3) low++;
      if (rsp3) begin
        nrsp++;
        rcyc = k;
        chk("hold_data", rd3, erd);
      end
    end
    chk("hold_ready_low", low, 5);
    chk("hold_rsp_count", nrsp, 1);
    chk("hold_rsp_cycle", rcyc, 5);
    @(negedge clk);
    rv3 = 1'b0;
    chk("hold_reaccept", 32'(rdy3), 32'd0);
    got = 0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (rsp3) begin
        got = k;
        break;
      end
    end
    chk("hold_latency2", got, 5);
    chk("hold_data2", rd3, erd);
    @(negedge clk);

    // Reset in BUSY discards the store
    @(negedge clk);
    drive(1, 1'b1, 3'b010, 32'h24, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    rv3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    chk("rst_busy_ready_low", 32'(rdy3), 32'd0);
    rst3 = 1'b0;
    nrsp = 0;
    @(negedge clk);
    chk("rst_busy_ready_high", 32'(rdy3), 32'd1);
    for (int k = 0; k < 8; k++) begin
      if (rsp3) nrsp++;
      @(negedge clk);
    end
    chk("rst_busy_no_rsp", nrsp, 0);
    txn(1, 1'b0, 3'b010, 32'h24, 32'h0);

    // Reset exactly at the access edge (WAIT_CYCLES=0) must block the write
    @(negedge clk);
    drive(0, 1'b1, 3'b010, 32'h28, 32'hFFFF_0000);
    @(posedge clk);
    @(negedge clk);
    rv0 = 1'b0;
    rst0 = 1'b1;
    @(negedge clk);
    chk("rst_access_no_rsp", 32'(rsp0), 32'd0);
    rst0 = 1'b0;
    #1;
    chk("rst_access_ready", 32'(rdy0), 32'd1);
    txn(0, 1'b0, 3'b010, 32'h28, 32'h0);

    // Randomised traffic on both instances
    for (int i = 0; i < 300; i++) begin
      txn(i % 2, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          32'($urandom_range(0, 511)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
